// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end.
//
// Contents:
//   XLEN             - datapath width (PC and instruction)
//   NOP_INSTR        - canonical NOP (addi x0, x0, 0) used for IF/ID bubbles
//   RESET_PC_DEFAULT - default PC loaded on reset
//   PerfCntW         - width of the optional fetch performance counters
//   fetch_state_e    - fetch FSM state encoding
//   sat_inc()        - saturating increment used by the performance counters

package core_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PerfCntW         = 32;

    typedef enum logic [2:0] {
        StIdle,  // one dead cycle after reset, no request
        StReq,   // imem_req high, waiting for imem_ready
        StWait,  // request accepted, waiting for imem_rvalid
        StHave,  // response held in the buffer, IF/ID not ready to take it
        StDrop   // request accepted for a squashed address, swallow its response
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PerfCntW-1:0] sat_inc(input logic [PerfCntW-1:0] value);
        return (&value) ? value : value + PerfCntW'(1);
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter for the fetch stage.
//
// Ports:
//   clk     - core clock, rising edge
//   reset   - synchronous active-high reset, clears the count
//   en_i    - count this cycle
//   count_o - current count, saturates at all-ones
//
// Only instantiated when FETCH_PERF_EN is defined.

module fetch_perf_counter
    import core_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    output logic [PerfCntW-1:0] count_o
);

    logic [PerfCntW-1:0] count_q;
    logic [PerfCntW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Instruction fetch stage controller of the 5-stage RV32I core.
//
// Owns the PC, the single-outstanding instruction-memory handshake and the IF/ID
// pipeline register. Takes PCWrite / IFIDWrite / IF_Flush from the hazard unit and
// the branch target from ID. Responses belonging to a squashed fetch are discarded.
//
// Ports:
//   clk, reset           - core clock (rising edge), synchronous active-high reset
//   PCWrite              - 1: PC may advance, 0: hold PC
//   IFIDWrite            - 1: IF/ID may load, 0: hold IF/ID
//   IF_Flush             - branch taken in ID: redirect PC, squash IF/ID
//   branch_target        - redirect address, used when IF_Flush=1
//   imem_req, imem_addr  - fetch request and address (address always equals PC)
//   imem_ready           - memory accepts the request this cycle
//   imem_rvalid/rdata    - fetch response
//   IFID_PC/Instr/valid  - IF/ID register contents (valid=0 is a bubble)
//   fetch_stall          - IF/ID took a bubble because no instruction was ready
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_stall_cnt - cycles with a fetch starvation bubble or IFIDWrite=0
//   perf_flush_cnt - IF_Flush cycles
//   Both saturate at all-ones. Without the macro these ports do not exist.

module fetch_stage_ctrl #(
    parameter int unsigned     XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IFIDWrite,
    input  logic            IF_Flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IFID_PC,
    output logic [XLEN-1:0] IFID_Instr,
    output logic            IFID_valid,
`ifdef FETCH_PERF_EN
    output logic            fetch_stall,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`else
    output logic            fetch_stall
`endif
);

    localparam logic [XLEN-1:0] Nop = XLEN'(core_pkg::NOP_INSTR);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    core_pkg::fetch_state_e state_q, state_d;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            imem_req_q, imem_req_d;

    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            fetch_stall_q, fetch_stall_d;

    // ------------------------------------------------------------------
    // Instruction availability and advance decision
    // ------------------------------------------------------------------
    logic            instr_avail;
    logic [XLEN-1:0] instr;
    logic            advance;
    logic            accept;

    always_comb begin
        instr_avail = ((state_q == core_pkg::StWait) && imem_rvalid) ||
                      (state_q == core_pkg::StHave);
        // The buffer only holds a live instruction in StHave.
        instr       = (state_q == core_pkg::StHave) ? buf_q : imem_rdata;
        advance     = instr_avail && PCWrite && IFIDWrite && !IF_Flush;
        accept      = imem_req_q && imem_ready;
    end

    // ------------------------------------------------------------------
    // Fetch FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        unique case (state_q)
            core_pkg::StIdle: begin
                state_d = core_pkg::StReq;
            end
            core_pkg::StReq: begin
                // An accepted request whose address is being squashed still owes
                // us a response; StDrop swallows it.
                if (accept) begin
                    state_d = IF_Flush ? core_pkg::StDrop : core_pkg::StWait;
                end
            end
            core_pkg::StWait: begin
                if (imem_rvalid) begin
                    if (IF_Flush || advance) begin
                        state_d = core_pkg::StReq;
                    end else begin
                        state_d = core_pkg::StHave;
                        buf_d   = imem_rdata;
                    end
                end else if (IF_Flush) begin
                    state_d = core_pkg::StDrop;
                end
            end
            core_pkg::StHave: begin
                if (IF_Flush || advance) begin
                    state_d = core_pkg::StReq;
                end
            end
            core_pkg::StDrop: begin
                if (imem_rvalid) begin
                    state_d = core_pkg::StReq;
                end
            end
            default: begin
                state_d = core_pkg::StIdle;
            end
        endcase
        // Request line is registered so it is glitch-free towards memory.
        imem_req_d = (state_d == core_pkg::StReq);
    end

    // ------------------------------------------------------------------
    // PC and IF/ID next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_stall_d = 1'b0;

        if (IF_Flush) begin
            // Flush overrides IFIDWrite: the squashed slot must not survive.
            pc_d         = branch_target;
            ifid_pc_d    = '0;
            ifid_instr_d = Nop;
            ifid_valid_d = 1'b0;
        end else if (!IFIDWrite) begin
            // Hold IF/ID and PC.
            pc_d = pc_q;
        end else if (advance) begin
            pc_d         = pc_q + XLEN'(4);
            ifid_pc_d    = pc_q;
            ifid_instr_d = instr;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_pc_d     = '0;
            ifid_instr_d  = Nop;
            ifid_valid_d  = 1'b0;
            // Only a starved fetch counts as a fetch stall; an available
            // instruction blocked by PCWrite=0 is a hazard bubble.
            fetch_stall_d = !instr_avail;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= core_pkg::StIdle;
            pc_q          <= RESET_PC;
            buf_q         <= Nop;
            imem_req_q    <= 1'b0;
            ifid_pc_q     <= '0;
            ifid_instr_q  <= Nop;
            ifid_valid_q  <= 1'b0;
            fetch_stall_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            imem_req_q    <= imem_req_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_stall_q <= fetch_stall_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign IFID_PC     = ifid_pc_q;
    assign IFID_Instr  = ifid_instr_q;
    assign IFID_valid  = ifid_valid_q;
    assign fetch_stall = fetch_stall_q;

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters: count on the same edge that registers the event.
    // ------------------------------------------------------------------
    logic stall_event;

    assign stall_event = fetch_stall_d || !IFIDWrite;

    fetch_perf_counter u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (stall_event),
        .count_o (perf_stall_cnt)
    );

    fetch_perf_counter u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (IF_Flush),
        .count_o (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: a table of per-cycle vectors with expected
// post-edge outputs, followed by a zero-wait-memory throughput sequence.

module tb_fetch_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IF_Flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_Instr;
    logic        IFID_valid;
    logic        fetch_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IF_Flush      (IF_Flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .IFID_PC       (IFID_PC),
        .IFID_Instr    (IFID_Instr),
        .IFID_valid    (IFID_valid),
        .fetch_stall   (fetch_stall)
    );

    typedef struct {
        logic        rst;
        logic        pw;
        logic        iw;
        logic        fl;
        logic [31:0] bt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_val;
        logic        e_stl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic pw, input logic iw,
                               input logic fl, input logic [31:0] bt, input logic rdy,
                               input logic rv, input logic [31:0] rd,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic [31:0] e_pc, input logic [31:0] e_ins,
                               input logic e_val, input logic e_stl);
        vec_t r;
        r.rst = rst; r.pw = pw; r.iw = iw; r.fl = fl; r.bt = bt; r.rdy = rdy;
        r.rv = rv; r.rd = rd; r.e_req = e_req; r.e_addr = e_addr; r.e_pc = e_pc;
        r.e_ins = e_ins; r.e_val = e_val; r.e_stl = e_stl;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        logic        acc_prev;
        logic [31:0] addr_prev;
        logic        acc_now;
        logic [31:0] addr_now;
        logic [31:0] exp_pc;
        int          n_valid;

        //        rst pw iw fl bt            rdy rv rd             req addr          IFID_PC       IFID_Instr    val stl
        // Reset.
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0, 0));
        // IDLE, then 3 starved REQ cycles; early rvalid must be ignored.
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'hBAD0BAD0, 1, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 1, 32'hBAD0BAD1, 1, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        32'h0,        NOP,          0, 1));
        // Zero-wait fetches of 0x0 and 0x4.
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'hAAAA0001, 1, 32'h4,        32'h0,        32'hAAAA0001, 1, 0));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h4,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'hAAAA0002, 1, 32'h8,        32'h4,        32'hAAAA0002, 1, 0));
        // Load-use stall: accept, response lands in HAVE, held 2 cycles, then released.
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h8,        32'h4,        32'hAAAA0002, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        1, 1, 32'h00000333, 0, 32'h8,        32'h4,        32'hAAAA0002, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h8,        32'h4,        32'hAAAA0002, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h8,        32'h4,        32'hAAAA0002, 1, 0));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'hC,        32'h8,        32'h00000333, 1, 0));
        // Flush in WAIT without rvalid -> DROP; stale 0xDEAD0000 swallowed 2 cycles later.
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 1, 32'h100,      1, 0, 32'h0,        0, 32'h100,      32'h0,        NOP,          0, 0));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h100,      32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'hDEAD0000, 1, 32'h100,      32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h100,      32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'h00500093, 1, 32'h104,      32'h100,      32'h00500093, 1, 0));
        // Flush together with rvalid in WAIT: flush wins, refetch next cycle.
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h104,      32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 1, 32'h200,      1, 1, 32'hCAFE0000, 1, 32'h200,      32'h0,        NOP,          0, 0));
        // Flush on an accepted request -> DROP; flush on an unaccepted one stays REQ.
        vecs.push_back(v(0, 1, 1, 1, 32'h300,      1, 0, 32'h0,        0, 32'h300,      32'h0,        NOP,          0, 0));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'hBEEF0000, 1, 32'h300,      32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 1, 32'h400,      0, 0, 32'h0,        1, 32'h400,      32'h0,        NOP,          0, 0));
        // PC wrap from 0xFFFF_FFFC.
        vecs.push_back(v(0, 1, 1, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        NOP,          0, 0));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'h12345678, 1, 32'h0,        32'hFFFFFFFC, 32'h12345678, 1, 0));
        // Into HAVE via IFIDWrite=0, then flush with IFIDWrite still 0.
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 0, 0, 32'h0,        1, 1, 32'h00000077, 0, 32'h0,        32'h0,        NOP,          0, 0));
        vecs.push_back(v(0, 1, 0, 1, 32'h500,      1, 0, 32'h0,        1, 32'h500,      32'h0,        NOP,          0, 0));
        // Reset while in WAIT; late rvalids in IDLE/first REQ ignored.
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h500,      32'h0,        NOP,          0, 1));
        vecs.push_back(v(1, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0, 0));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 1, 32'hBAD0BAD2, 1, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        0, 1, 32'hBAD0BAD3, 1, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h0,        1, 1, 32'h13579BDF, 1, 32'h4,        32'h0,        32'h13579BDF, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            PCWrite       = vecs[i].pw;
            IFIDWrite     = vecs[i].iw;
            IF_Flush      = vecs[i].fl;
            branch_target = vecs[i].bt;
            imem_ready    = vecs[i].rdy;
            imem_rvalid   = vecs[i].rv;
            imem_rdata    = vecs[i].rd;
            @(posedge clk);
            #1;
            chk("imem_req",    i, 32'(imem_req),    32'(vecs[i].e_req));
            chk("imem_addr",   i, imem_addr,        vecs[i].e_addr);
            chk("IFID_PC",     i, IFID_PC,          vecs[i].e_pc);
            chk("IFID_Instr",  i, IFID_Instr,       vecs[i].e_ins);
            chk("IFID_valid",  i, 32'(IFID_valid),  32'(vecs[i].e_val));
            chk("fetch_stall", i, 32'(fetch_stall), 32'(vecs[i].e_stl));
        end

        // Zero-wait memory for 20 cycles starting in REQ at PC 0x4:
        // one instruction every 2 cycles, data tagged with its address.
        acc_prev  = 1'b0;
        addr_prev = 32'h0;
        exp_pc    = 32'h4;
        n_valid   = 0;
        reset     = 1'b0;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IF_Flush  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            imem_ready  = 1'b1;
            imem_rvalid = acc_prev;
            imem_rdata  = {16'hC0DE, addr_prev[15:0]};
            acc_now     = imem_req;
            addr_now    = imem_addr;
            @(posedge clk);
            #1;
            if (IFID_valid === 1'b1) begin
                chk("tput_pc",    100 + c, IFID_PC,    exp_pc);
                chk("tput_instr", 100 + c, IFID_Instr, {16'hC0DE, exp_pc[15:0]});
                exp_pc = exp_pc + 32'h4;
                n_valid++;
            end
            acc_prev  = acc_now;
            addr_prev = addr_now;
        end
        chk("tput_count", 200, 32'(n_valid), 32'd10);
        chk("tput_addr",  201, imem_addr,    32'h2C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
